// File: rtl/ifu_fb_if.sv
// F2 fetch return, flush/pop controls and aligner-facing fetch buffer view.
// master drives the fetch/aligner inputs; slave is the fetch buffer itself.
interface ifu_fb_if #(
    parameter int DATA_W = 64
);
    logic              ifc_fetch_req_f2;
    logic              ic_hit_f2;
    logic [30:0]       ifc_fetch_addr_f2;
    logic [DATA_W-1:0] ic_data_f2;
    logic              ic_access_fault_f2;
    logic              exu_flush_final;
    logic              dec_takenbr;
    logic              aln_pop1;
    logic              aln_pop2;

    logic              fb0_valid;
    logic              fb1_valid;
    logic [30:0]       fb0_pc;
    logic [30:0]       fb1_pc;
    logic [DATA_W-1:0] fb0_data;
    logic [DATA_W-1:0] fb1_data;
    logic              fb0_fault;
    logic              fb1_fault;
    logic              ifu_fb_consume1;
    logic              ifu_fb_consume2;
    logic [2:0]        fb_count;
    logic              fb_err;

    modport master (
        output ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2, ic_data_f2,
               ic_access_fault_f2, exu_flush_final, dec_takenbr, aln_pop1, aln_pop2,
        input  fb0_valid, fb1_valid, fb0_pc, fb1_pc, fb0_data, fb1_data,
               fb0_fault, fb1_fault, ifu_fb_consume1, ifu_fb_consume2, fb_count, fb_err
    );

    modport slave (
        input  ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2, ic_data_f2,
               ic_access_fault_f2, exu_flush_final, dec_takenbr, aln_pop1, aln_pop2,
        output fb0_valid, fb1_valid, fb0_pc, fb1_pc, fb0_data, fb1_data,
               fb0_fault, fb1_fault, ifu_fb_consume1, ifu_fb_consume2, fb_count, fb_err
    );
endinterface

// File: rtl/ifu_fetch_buf.sv
// Circular F2 packet buffer feeding the aligner: writes visible one cycle later, pops and
// consume echoes act in the same cycle; no backpressure, overflow is dropped and flagged in fb_err.
module ifu_fetch_buf #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic     clk,
    input  logic     rst,
    ifu_fb_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_fault;
    logic [30:0]       ent_pc   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    ptr_t rd_ptr;
    ptr_t wr_ptr;
    ptr_t rd_ptr1;
    cnt_t count;
    cnt_t count_nxt;
    logic err_q;

    logic       flush;
    logic       wr_req;
    logic       wr_en;
    logic       full_drop;
    logic       pop_under;
    logic       err_set;
    logic [1:0] pop_req;
    logic [1:0] pop_eff;
    logic [DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0] set_mask;

    always_comb begin
        flush   = bus.exu_flush_final | bus.dec_takenbr;
        wr_req  = bus.ifc_fetch_req_f2 & bus.ic_hit_f2;
        pop_req = bus.aln_pop2 ? 2'd2 : (bus.aln_pop1 ? 2'd1 : 2'd0);
        rd_ptr1 = rd_ptr + ptr_t'(1);

        // Over-popping retires only what is present; count < pop_req <= 2 fits in two bits.
        pop_under = cnt_t'(pop_req) > count;
        pop_eff   = pop_under ? 2'(count) : pop_req;

        // A full buffer can still take a write when the same cycle frees a slot.
        full_drop = wr_req & ~flush & (count == cnt_t'(DEPTH)) & (pop_eff == 2'd0);
        wr_en     = wr_req & ~flush & ~full_drop;
        err_set   = full_drop | (~flush & ((bus.aln_pop1 & bus.aln_pop2) | pop_under));
        count_nxt = count + cnt_t'(wr_en) - cnt_t'(pop_eff);
    end

    // Popped slots are cleared before the write mask, so a write landing in a slot
    // freed this cycle (full buffer with pop) ends up valid.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_mask[i] = ((pop_eff != 2'd0) && (ptr_t'(i) == rd_ptr)) ||
                          ((pop_eff == 2'd2) && (ptr_t'(i) == rd_ptr1));
            set_mask[i] = wr_en && (ptr_t'(i) == wr_ptr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_fault <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]   <= '0;
                ent_data[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            ent_valid <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            ent_valid <= (ent_valid & ~clr_mask) | set_mask;
            if (wr_en) begin
                ent_pc[wr_ptr]    <= bus.ifc_fetch_addr_f2;
                ent_data[wr_ptr]  <= bus.ic_data_f2;
                ent_fault[wr_ptr] <= bus.ic_access_fault_f2;
                wr_ptr            <= wr_ptr + ptr_t'(1);
            end
            rd_ptr <= rd_ptr + ptr_t'(pop_eff);
            count  <= count_nxt;
        end
    end

    // Sticky: survives flushes, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.fb0_valid       = ent_valid[rd_ptr]  & (count != '0);
        bus.fb1_valid       = ent_valid[rd_ptr1] & (count > cnt_t'(1));
        bus.fb0_pc          = bus.fb0_valid ? ent_pc[rd_ptr]     : '0;
        bus.fb1_pc          = bus.fb1_valid ? ent_pc[rd_ptr1]    : '0;
        bus.fb0_data        = bus.fb0_valid ? ent_data[rd_ptr]   : '0;
        bus.fb1_data        = bus.fb1_valid ? ent_data[rd_ptr1]  : '0;
        bus.fb0_fault       = bus.fb0_valid & ent_fault[rd_ptr];
        bus.fb1_fault       = bus.fb1_valid & ent_fault[rd_ptr1];
        bus.ifu_fb_consume1 = (pop_eff == 2'd1) & ~flush;
        bus.ifu_fb_consume2 = (pop_eff == 2'd2) & ~flush;
        bus.fb_count        = 3'(count);
        bus.fb_err          = err_q;
    end
endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Directed bench for ifu_fetch_buf: stimulus queues cycle-tagged expectations and expected
// popped PCs; a negedge monitor compares them against what the buffer presents.
module tb_ifu_fetch_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fb_if #(.DATA_W(64)) bus ();

    ifu_fetch_buf #(.DEPTH(4), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {S_CNT, S_ERR, S_V0, S_V1, S_PC0, S_PC1, S_D0, S_F0, S_C1, S_C2} sel_t;
    typedef struct {
        int          cyc;
        sel_t        sel;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [30:0] pop_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pkt_data(input logic [30:0] pc);
        return {16'hA5C3, 17'h0, pc};
    endfunction

    function automatic logic [63:0] observe(input sel_t s);
        case (s)
            S_CNT:   return 64'(bus.fb_count);
            S_ERR:   return 64'(bus.fb_err);
            S_V0:    return 64'(bus.fb0_valid);
            S_V1:    return 64'(bus.fb1_valid);
            S_PC0:   return 64'(bus.fb0_pc);
            S_PC1:   return 64'(bus.fb1_pc);
            S_D0:    return bus.fb0_data;
            S_F0:    return 64'(bus.fb0_fault);
            S_C1:    return 64'(bus.ifu_fb_consume1);
            default: return 64'(bus.ifu_fb_consume2);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: cycle-tagged status checks plus popped-packet scoreboard.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_%s cycle=%0d actual=none expected=%0h",
                         exp_q[i].sel.name(), exp_q[i].cyc, exp_q[i].val);
                exp_q.delete(i);
            end else if (exp_q[i].cyc == cyc) begin
                check(exp_q[i].sel.name(), observe(exp_q[i].sel), exp_q[i].val);
                exp_q.delete(i);
            end
        end
        check("consume_excl", 64'(bus.ifu_fb_consume1 & bus.ifu_fb_consume2), 64'd0);
        if (bus.ifu_fb_consume1 || bus.ifu_fb_consume2) begin
            for (int k = 0; k < (bus.ifu_fb_consume2 ? 2 : 1); k++) begin
                if (pop_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_consume cycle=%0d actual=pop expected=none", cyc);
                end else begin
                    logic [30:0] p;
                    p = pop_q.pop_front();
                    check(k == 0 ? "pop_pc0" : "pop_pc1",
                          64'(k == 0 ? bus.fb0_pc : bus.fb1_pc), 64'(p));
                    check(k == 0 ? "pop_data0" : "pop_data1",
                          k == 0 ? bus.fb0_data : bus.fb1_data, pkt_data(p));
                end
            end
        end
    end

    task automatic ex(input int off, input sel_t s, input logic [63:0] v);
        exp_q.push_back('{cyc + off, s, v});
    endtask

    task automatic drive(input logic req, input logic hit, input logic [30:0] pc, input logic flt,
                         input logic fl, input logic tbr, input logic p1, input logic p2);
        bus.ifc_fetch_req_f2   = req;
        bus.ic_hit_f2          = hit;
        bus.ifc_fetch_addr_f2  = pc;
        bus.ic_data_f2         = pkt_data(pc);
        bus.ic_access_fault_f2 = flt;
        bus.exu_flush_final    = fl;
        bus.dec_takenbr        = tbr;
        bus.aln_pop1           = p1;
        bus.aln_pop2           = p2;
    endtask

    task automatic step(input logic req, input logic hit, input logic [30:0] pc, input logic flt,
                        input logic fl, input logic tbr, input logic p1, input logic p2);
        @(posedge clk);
        #1;
        drive(req, hit, pc, flt, fl, tbr, p1, p2);
    endtask

    task automatic wr(input logic [30:0] pc);
        step(1'b1, 1'b1, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        ex(0, S_CNT, 0); ex(0, S_V0, 0); ex(0, S_V1, 0); ex(0, S_ERR, 0); ex(0, S_PC0, 0); ex(0, S_C1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill, visibility latency, pop2 with write into a full buffer, wrap-around.
        wr(31'h100);
        wr(31'h104);
        ex(0, S_V0, 1); ex(0, S_PC0, 31'h100); ex(0, S_V1, 0); ex(0, S_CNT, 1);
        step(1'b1, 1'b1, 31'h108, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(0, S_PC0, 31'h100); ex(0, S_PC1, 31'h104); ex(0, S_V1, 1); ex(0, S_D0, pkt_data(31'h100));
        ex(1, S_CNT, 3);
        wr(31'h10C);
        step(1'b1, 1'b1, 31'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ex(0, S_CNT, 4); ex(0, S_C2, 1); ex(0, S_C1, 0);
        pop_q.push_back(31'h100); pop_q.push_back(31'h104);
        step(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ex(0, S_CNT, 3); ex(0, S_PC0, 31'h108); ex(0, S_F0, 1); ex(0, S_C1, 1);
        pop_q.push_back(31'h108);
        step(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ex(0, S_PC1, 31'h200); ex(0, S_V1, 1);
        pop_q.push_back(31'h10C);
        wr(31'h300);
        ex(0, S_PC0, 31'h200); ex(0, S_CNT, 1); ex(0, S_ERR, 0); ex(0, S_F0, 0);

        // Flush overrides a same-cycle pop and write; pointers restart at 0.
        step(1'b1, 1'b1, 31'h400, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        ex(0, S_CNT, 2); ex(0, S_C1, 0); ex(0, S_C2, 0);
        wr(31'h500);
        ex(0, S_CNT, 0); ex(0, S_V0, 0); ex(0, S_PC0, 0);
        step(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ex(0, S_V0, 1); ex(0, S_PC0, 31'h500); ex(0, S_CNT, 1); ex(0, S_C1, 1);
        pop_q.push_back(31'h500);

        // Full buffer: write with no pop is dropped and flagged.
        wr(31'h800);
        ex(0, S_CNT, 0); ex(0, S_ERR, 0);
        wr(31'h804);
        wr(31'h808);
        wr(31'h80C);
        wr(31'h900);
        ex(0, S_CNT, 4); ex(0, S_PC0, 31'h800); ex(0, S_ERR, 0);
        idle();
        ex(0, S_CNT, 4); ex(0, S_PC0, 31'h800); ex(0, S_PC1, 31'h804); ex(0, S_ERR, 1);
        step(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop_q.push_back(31'h800); pop_q.push_back(31'h804);
        step(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ex(0, S_PC0, 31'h808);
        pop_q.push_back(31'h808); pop_q.push_back(31'h80C);
        idle();
        ex(0, S_CNT, 0); ex(0, S_V0, 0); ex(0, S_ERR, 1);

        // Asynchronous reset asserted mid-cycle during a write.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 31'h950, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(0, S_CNT, 0); ex(0, S_ERR, 0); ex(0, S_V0, 0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(0, S_CNT, 0); ex(0, S_ERR, 0); ex(0, S_V0, 0);

        // Pop while empty, write under taken branch, cache miss, sticky error across flush.
        step(1'b0, 1'b0, 31'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ex(0, S_C1, 0); ex(0, S_C2, 0); ex(0, S_CNT, 0); ex(0, S_ERR, 0);
        step(1'b1, 1'b1, 31'h600, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ex(0, S_ERR, 1); ex(0, S_CNT, 0);
        step(1'b1, 1'b0, 31'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex(0, S_ERR, 1); ex(0, S_CNT, 0); ex(0, S_V0, 0);
        step(1'b0, 1'b0, 31'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ex(0, S_CNT, 0); ex(0, S_V0, 0);
        idle();
        ex(0, S_ERR, 1); ex(0, S_CNT, 0);
        idle();
        repeat (2) @(posedge clk);
        #1;

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_expect actual=%0d expected=0", exp_q.size());
        end
        if (pop_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL missing_consume actual=%0d expected=0", pop_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifu_fetch_buf.md
Name: ifu_fetch_buf

Overview:
- Four-entry circular fetch buffer between the I-cache/ICCM F2 data return and the instruction aligner.
- Captures each valid F2 fetch packet with its PC and fault status, and presents the two oldest packets to the aligner.
- Accepts aligner pop commands and returns them to the fetch controller as ifu_fb_consume1/ifu_fb_consume2, so the controller's mass-balance model stays exact.
- Flushed on exu_flush_final or dec_takenbr.

Parameters:
- DEPTH, 4: number of packet entries; power of two, minimum 2.
- DATA_W, 64: fetch packet width in bits (four 16-bit parcels).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- ifc_fetch_req_f2  input  1  F2 fetch valid (already killed by flush)
- ic_hit_f2  input  1  F2 data valid (cache hit, ICCM hit or crit word)
- ifc_fetch_addr_f2  input  31  F2 packet PC [31:1]
- ic_data_f2  input  DATA_W  F2 packet data
- ic_access_fault_f2  input  1  F2 packet access fault
- exu_flush_final  input  1  flush
- dec_takenbr  input  1  decode taken branch, treated as flush
- aln_pop1  input  1  aligner retires the oldest entry
- aln_pop2  input  1  aligner retires the two oldest entries
- fb0_valid, fb1_valid  output  1  head / next entry valid
- fb0_pc, fb1_pc  output  31  entry PC
- fb0_data, fb1_data  output  DATA_W  entry data
- fb0_fault, fb1_fault  output  1  entry fault
- ifu_fb_consume1  output  1  one entry retired this cycle
- ifu_fb_consume2  output  1  two entries retired this cycle
- fb_count  output  3  occupancy, 0..DEPTH
- fb_err  output  1  sticky protocol error

Behaviour:
- State: rd_ptr and wr_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH; count register; per-entry valid, pc, data and fault.
- Reset: all entry valids 0, both pointers 0, count 0, fb_err 0. All outputs are 0 during and after reset until the first write.
- Write condition: wr_en = ifc_fetch_req_f2 & ic_hit_f2 & ~flush, where flush = exu_flush_final | dec_takenbr.
  - The entry at wr_ptr is loaded and wr_ptr advances by 1.
  - Write-to-visibility latency is one cycle: a packet written in cycle N appears on fb0/fb1 in N+1. There is no combinational bypass.
- Pop: pop_n = 2 if aln_pop2, else 1 if aln_pop1, else 0.
  - aln_pop2 wins if both pops are asserted. fb_err is set in that case.
  - If pop_n exceeds count, pop only count entries and set fb_err.
  - rd_ptr advances by the effective pop count; popped entry valids are cleared.
- Consume outputs are combinational, same cycle as the pop:
  - ifu_fb_consume1 = (effective pop == 1) & ~flush
  - ifu_fb_consume2 = (effective pop == 2) & ~flush
  - The two are mutually exclusive.
- Simultaneous write and pop: both take effect. The next count is count + wr_en - pop. A write into a full buffer is accepted only if the same cycle pops at least one entry.
- Full:
  - Condition: count == DEPTH, no pop, and wr_en.
  - The write is dropped, pointers and contents are unchanged, and fb_err is set.
  - The fetch controller's mass balance is required to make this unreachable; the bench checks it never occurs in legal traffic.
- Empty: fb0_valid = 0 and fb1_valid = 0. Pops while empty set fb_err and do not move rd_ptr.
- Head outputs:
  - fb0 shows entry[rd_ptr]; fb1 shows entry[rd_ptr+1 mod DEPTH].
  - fbN_valid = entry valid and count > N.
  - Data, pc and fault are forced to 0 when the entry is invalid.
- Flush (exu_flush_final or dec_takenbr):
  - Clears all valids, sets rd_ptr = wr_ptr = 0 and count = 0, overriding any write or pop in that cycle.
  - fb_err is not cleared by flush.
- Wrap-around: pointers wrap DEPTH-1 -> 0 without bubble. fb1 at rd_ptr = DEPTH-1 reads entry 0.
- Clear of fb_err: reset only.
- Reset mid-operation: asynchronous; all state clears immediately regardless of in-flight write or pop.

Test Plan:
- Reset, then write PCs 0x100, 0x104, 0x108 (ic_hit_f2=1) in 3 consecutive cycles, no pops -> fb0_pc=0x100, fb1_pc=0x104 one cycle after the second write; fb_count=3 after the third.
- Fill to 4, then in the next cycle assert aln_pop2 and a write of 0x200 -> ifu_fb_consume2=1 that cycle; next cycle fb_count=3, fb0_pc=0x108; after 2 more pop1 cycles fb0_pc=0x200, having wrapped through entry 0; fb_err=0.
- Buffer holds 2 entries; assert exu_flush_final together with aln_pop1 and an F2 write -> next cycle fb_count=0, fb0_valid=0, ifu_fb_consume1=0 in the flush cycle, pointers are 0.
- Empty buffer, assert aln_pop1 -> ifu_fb_consume1=0, fb_count stays 0, fb_err=1 and stays 1 through a later flush.
- Full buffer, write with no pop -> write dropped, fb0_pc unchanged, fb_count=4, fb_err=1.
- Write with ic_hit_f2=0 (miss), and a write in a dec_takenbr cycle -> no entry created, fb_count unchanged or 0 respectively.
